// File: rtl/pc_unit_pkg.sv
// ============================================================
// pc_unit_pkg : pc_src encodings, FSM state type, default vectors
// Rev 1.0
// ============================================================
`default_nettype none

package pc_unit_pkg;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JR     = 2'b11;

    localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_VECTOR  = 32'h0000_0080;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_unit_if.sv
// ============================================================
// pc_unit_if : fetch-control bundle between core and pc_unit
// Rev 1.0
// ============================================================
`default_nettype none

interface pc_unit_if;

    logic        imem_ready;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic [31:0] jump_address;
    logic [31:0] jr_target;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        misalign_fault;
    logic [31:0] epc;

    modport slave (
        input  imem_ready, pc_src, branch_taken, branch_offset,
               jump_address, jr_target, halt,
        output pc, pc_plus4, fetch_valid, halted, misalign_fault, epc
    );

    modport master (
        output imem_ready, pc_src, branch_taken, branch_offset,
               jump_address, jr_target, halt,
        input  pc, pc_plus4, fetch_valid, halted, misalign_fault, epc
    );

endinterface

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================
// pc_next_sel : combinational next-PC mux and branch adder
// Rev 1.0
// ============================================================
`default_nettype none

module pc_next_sel
    import pc_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jump_address,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] w_branch_target;

    // Offset is in words; the shift and add wrap modulo 2^32.
    assign w_branch_target = pc_plus4 + (branch_offset << 2);

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PC_SEQ:    next_pc = pc_plus4;
            PC_BRANCH: next_pc = branch_taken ? w_branch_target : pc_plus4;
            PC_JUMP:   next_pc = jump_address;
            PC_JR:     next_pc = jr_target;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================
// pc_unit : BOOT/RUN/HALT program counter with fetch stall.
// Optional misalignment trap: define PC_MISALIGN_TRAP_EN.
// Rev 1.0
// ============================================================
`default_nettype none

module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = C_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = C_TRAP_VECTOR
)(
    input  logic          clk,
    input  logic          rst_n,
    pc_unit_if.slave      bus
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_accept;

    assign w_pc_plus4 = r_pc + 32'd4;

    pc_next_sel u_next_sel (
        .pc_plus4      (w_pc_plus4),
        .pc_src        (bus.pc_src),
        .branch_taken  (bus.branch_taken),
        .branch_offset (bus.branch_offset),
        .jump_address  (bus.jump_address),
        .jr_target     (bus.jr_target),
        .next_pc       (w_target)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = RUN;
            RUN:     w_next_state = bus.halt ? HALT : RUN;
            HALT:    w_next_state = HALT;
            default: w_next_state = BOOT;
        endcase
    end

    // halt takes priority over any fetch update, including a trap.
    assign w_accept = (r_state == RUN) && !bus.halt && bus.imem_ready;

`ifdef PC_MISALIGN_TRAP_EN
    logic        r_fault;
    logic [31:0] r_epc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_VECTOR;
            r_fault <= 1'b0;
            r_epc   <= 32'h0000_0000;
        end else begin
            r_fault <= 1'b0;
            if (w_accept) begin
                if (w_target[1:0] != 2'b00) begin
                    r_pc    <= TRAP_VECTOR;
                    r_epc   <= w_target;
                    r_fault <= 1'b1;
                end else begin
                    r_pc <= w_target;
                end
            end
        end
    end

    assign bus.misalign_fault = r_fault;
    assign bus.epc            = r_epc;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_VECTOR;
        end else if (w_accept) begin
            r_pc <= w_target & 32'hFFFF_FFFC;
        end
    end

    assign bus.misalign_fault = 1'b0;
    assign bus.epc            = 32'h0000_0000;
`endif

    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.fetch_valid = (r_state == RUN);
    assign bus.halted      = (r_state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: spec-level reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
`default_nettype none

module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    pc_unit_if bus ();

    pc_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch unit must show, from the rules alone.
    logic        m_known = 1'b0;
    logic        m_boot, m_halt, m_fault;
    logic [31:0] m_pc, m_epc, m_tgt;

    function automatic logic [31:0] spec_target(input logic [31:0] pc, input logic [1:0] src,
                                                input logic taken, input logic [31:0] off,
                                                input logic [31:0] ja, input logic [31:0] jr);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (src == 2'd0)      return seq;
        else if (src == 2'd1) return taken ? seq + off * 32'd4 : seq;
        else if (src == 2'd2) return ja;
        else                  return jr;
    endfunction

    always_comb m_tgt = spec_target(m_pc, bus.pc_src, bus.branch_taken, bus.branch_offset,
                                    bus.jump_address, bus.jr_target);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known <= 1'b1;
            m_boot  <= 1'b1;
            m_halt  <= 1'b0;
            m_fault <= 1'b0;
            m_pc    <= RV;
            m_epc   <= 32'h0;
        end else if (m_known) begin
            m_fault <= 1'b0;
            if (m_boot) begin
                m_boot <= 1'b0;
            end else if (!m_halt) begin
                if (bus.halt) begin
                    m_halt <= 1'b1;
                end else if (bus.imem_ready) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (m_tgt % 32'd4 != 32'd0) begin
                        m_pc    <= TV;
                        m_epc   <= m_tgt;
                        m_fault <= 1'b1;
                    end else begin
                        m_pc <= m_tgt;
                    end
`else
                    m_pc <= m_tgt - (m_tgt % 32'd4);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("model_pc",       bus.pc,                     m_pc);
            chk("model_pc_plus4", bus.pc_plus4,               m_pc + 32'd4);
            chk("model_fetch_v",  {31'd0, bus.fetch_valid},   {31'd0, !m_boot && !m_halt});
            chk("model_halted",   {31'd0, bus.halted},        {31'd0, m_halt});
            chk("model_fault",    {31'd0, bus.misalign_fault},{31'd0, m_fault});
            chk("model_epc",      bus.epc,                    m_epc);
        end
    end

    task automatic drive(input logic rdy, input logic [1:0] src, input logic tk,
                         input logic [31:0] off, input logic [31:0] ja,
                         input logic [31:0] jr, input logic h);
        bus.imem_ready    = rdy;
        bus.pc_src        = src;
        bus.branch_taken  = tk;
        bus.branch_offset = off;
        bus.jump_address  = ja;
        bus.jr_target     = jr;
        bus.halt          = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_pc",     bus.pc, 32'h0);
        chk("rst_fv",     {31'd0, bus.fetch_valid}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_fault",  {31'd0, bus.misalign_fault}, 32'd0);
        chk("rst_epc",    bus.epc, 32'h0);

        rst_n = 1'b1;
        tick();
        chk("boot_exit_pc", bus.pc, 32'h0);
        chk("boot_exit_fv", {31'd0, bus.fetch_valid}, 32'd1);
        tick();
        chk("seq_pc4", bus.pc, 32'h4);
        tick();
        chk("seq_pc8", bus.pc, 32'h8);

        // Backward branch from address 0 wraps below zero.
        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("jump_zero", bus.pc, 32'h0);
        drive(1'b1, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0);
        tick();
        chk("branch_wrap", bus.pc, 32'hFFFF_FFFC);
        drive(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("seq_wrap", bus.pc, 32'h0);
        chk("seq_wrap_p4", bus.pc_plus4, 32'h4);

        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h0040_0010, 32'h0, 1'b0);
        tick();
        drive(1'b1, 2'd1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        tick();
        chk("branch_taken", bus.pc, 32'h0040_0004);
        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h0040_0010, 32'h0, 1'b0);
        tick();
        drive(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        tick();
        chk("branch_not_taken", bus.pc, 32'h0040_0014);

        drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0040_0100, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bus.pc, 32'h0040_0014);
        end
        bus.imem_ready = 1'b1;
        tick();
        chk("stall_release", bus.pc, 32'h0040_0100);

        drive(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0000_1002, 1'b0);
        tick();
`ifdef PC_MISALIGN_TRAP_EN
        chk("trap_pc",    bus.pc, 32'h80);
        chk("trap_epc",   bus.epc, 32'h1002);
        chk("trap_fault", {31'd0, bus.misalign_fault}, 32'd1);
        drive(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("trap_pulse_end", {31'd0, bus.misalign_fault}, 32'd0);
        chk("trap_after_pc",  bus.pc, 32'h84);
`else
        chk("jr_align_pc", bus.pc, 32'h1000);
        chk("jr_no_fault", {31'd0, bus.misalign_fault}, 32'd0);
`endif

        // halt together with a misaligned target and no ready: halt wins.
        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h0000_0020, 32'h0, 1'b0);
        tick();
        drive(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0000_2002, 1'b1);
        tick();
        chk("halt_halted", {31'd0, bus.halted}, 32'd1);
        chk("halt_fv",     {31'd0, bus.fetch_valid}, 32'd0);
        chk("halt_fault",  {31'd0, bus.misalign_fault}, 32'd0);
        drive(1'b1, 2'd2, 1'b1, 32'h4, 32'h0000_0400, 32'h0000_0800, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold_pc", bus.pc, 32'h20);
        end
        rst_n = 1'b0;
        tick();
        chk("halt_rst_pc",     bus.pc, 32'h0);
        chk("halt_rst_halted", {31'd0, bus.halted}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-stall.
        drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_0300, 32'h0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("stall_rst_fv", {31'd0, bus.fetch_valid}, 32'd0);
        rst_n = 1'b1;
        bus.imem_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_jump", bus.pc, 32'h300);

        // Reset on the same edge as a misaligned update.
        drive(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0000_1003, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("rst_vs_trap_pc",    bus.pc, 32'h0);
        chk("rst_vs_trap_fault", {31'd0, bus.misalign_fault}, 32'd0);
        chk("rst_vs_trap_epc",   bus.epc, 32'h0);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        chk("final_seq", bus.pc, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC value loaded by reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0080, the PC value loaded on a misalignment trap.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 imem_ready  in  1  instruction memory accepts the fetch at pc this cycle.
REQ-006 pc_src  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-007 branch_taken  in  1  branch condition true; meaningful only when pc_src=01.
REQ-008 branch_offset  in  32  sign-extended 16-bit immediate, word units.
REQ-009 jump_address  in  32  pseudo-direct jump target {pc_plus4[31:28], target, 2'b00} from the jump-address stage.
REQ-010 jr_target  in  32  register-sourced target.
REQ-011 halt  in  1  stop fetching permanently until reset.
REQ-012 pc  out  32  current fetch address.
REQ-013 pc_plus4  out  32  pc+4, fed combinationally to the jump-address and branch-target logic.
REQ-014 fetch_valid  out  1  pc is a valid fetch request this cycle.
REQ-015 halted  out  1  unit is in HALT.
REQ-016 misalign_fault  out  1  one-cycle pulse on a misalignment trap.
REQ-017 epc  out  32  offending target address of the last trap.

Function
REQ-018 SHALL implement FSM states BOOT, RUN, HALT.
REQ-019 BOOT: entered on reset; fetch_valid=0; always moves to RUN on the next cycle; pc holds RESET_VECTOR.
REQ-020 RUN: fetch_valid=1; pc updates only when imem_ready=1; when imem_ready=0, pc and all outputs hold (stall).
REQ-021 The next pc SHALL be: 00 -> pc_plus4; 01 -> pc_plus4+(branch_offset<<2) if branch_taken, else pc_plus4; 10 -> jump_address; 11 -> jr_target.
REQ-022 All address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0; a negative branch offset below 0 wraps.
REQ-023 pc_plus4 SHALL equal pc+4 combinationally in every state.
REQ-024 When halt=1 in RUN, the unit SHALL move to HALT on that edge regardless of imem_ready, and pc SHALL hold its current value.
REQ-025 In HALT, fetch_valid=0 and halted=1; only reset exits HALT.
REQ-026 Inputs pc_src, branch_*, jump_address, and jr_target SHALL be ignored in BOOT and HALT.
REQ-027 Latency: the selected target appears on pc one cycle after the edge on which imem_ready=1.

Reset
REQ-028 While rst_n=0 at a rising edge: state=BOOT, pc=RESET_VECTOR, fetch_valid=0, halted=0, misalign_fault=0, epc=0.
REQ-029 Reset asserted mid-stall, mid-trap, or in HALT SHALL override every other event on that edge.

Configuration
REQ-030 Macro PC_MISALIGN_TRAP_EN defined: if the selected next pc has bits[1:0]!=0 and the update is accepted, pc SHALL load TRAP_VECTOR, epc SHALL load the offending address, and misalign_fault SHALL pulse for exactly one cycle.
REQ-031 Macro undefined: next-pc bits[1:0] SHALL be forced to 00, misalign_fault SHALL be tied to 0, and epc SHALL be tied to 0.
REQ-032 halt and a misaligned target on the same edge: halt wins, no trap, pc holds.

Structure
REQ-033 Shared package SHALL hold the pc_src encodings (PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR), the FSM state typedef, and the default vector constants.
REQ-034 A sub-module pc_next_sel SHALL implement the combinational target selection and branch adder; pc_unit SHALL hold the FSM and registers.

Verification
REQ-035 Release reset with imem_ready=1 and pc_src=00 -> one cycle with fetch_valid=0, then pc = 0, 4, 8, ...
REQ-036 pc=0x0040_0010, pc_src=01, branch_taken=1, offset=0xFFFF_FFFC -> next pc=0x0040_0004; with branch_taken=0 -> 0x0040_0014.
REQ-037 pc_src=10, jump_address=0x0040_0100, imem_ready=0 for 3 cycles then 1 -> pc holds for 3 cycles, then becomes 0x0040_0100.
REQ-038 pc=0xFFFF_FFFC, pc_src=00 -> pc=0x0000_0000.
REQ-039 With PC_MISALIGN_TRAP_EN defined, pc_src=11 and jr_target=0x0000_1002 -> pc=0x80, epc=0x1002, one-cycle fault pulse; with the macro undefined -> pc=0x1000.
REQ-040 halt=1 at pc=0x20 -> halted=1, fetch_valid=0, pc stays 0x20 for 10 cycles; rst_n=0 -> BOOT and pc=0.
